// File: rtl/dcache_pkg.sv
// Shared types, funct3 encodings and address-field width helpers for the 2-way data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    REFILL
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic int off_w(input int block_words);
    return $clog2(block_words) + 2;
  endfunction

  function automatic int idx_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int tag_w(input int addr_width, input int num_sets, input int block_words);
    return addr_width - idx_w(num_sets) - off_w(block_words);
  endfunction

endpackage

// File: rtl/dcache_align.sv
// Load extract/extend and store byte-lane merge on one 32-bit cached word.
module dcache_align
  import dcache_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  output logic [31:0] load_data,
  output logic [31:0] store_word,
  output logic        store_en
);

  logic [4:0]  sh;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // NOTE: every output gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    sh         = {byte_off, 3'b000};
    byte_v     = word[sh +: 8];
    half_v     = byte_off[1] ? word[31:16] : word[15:0];
    load_data  = '0;
    store_word = word;
    store_en   = 1'b0;

    case (funct3)
      F3_B:  load_data = {{24{byte_v[7]}}, byte_v};
      F3_H:  load_data = {{16{half_v[15]}}, half_v};
      F3_W:  load_data = word;
      F3_BU: load_data = {24'b0, byte_v};
      F3_HU: load_data = {16'b0, half_v};
      default: load_data = '0;
    endcase

    case (funct3)
      F3_B: begin
        store_word[sh +: 8] = wdata[7:0];
        store_en            = 1'b1;
      end
      F3_H: begin
        if (byte_off[1]) store_word[31:16] = wdata[15:0];
        else             store_word[15:0]  = wdata[15:0];
        store_en = 1'b1;
      end
      F3_W: begin
        store_word = wdata;
        store_en   = 1'b1;
      end
      default: store_en = 1'b0;
    endcase
  end

endmodule

// File: rtl/dcache_2way.sv
// 2-way set-associative write-back, write-allocate data cache with per-set LRU
// and a ready/valid miss FSM towards main memory.
module dcache_2way
  import dcache_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int NUM_SETS    = 4,
  parameter int BLOCK_WORDS = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cpu_req,
  input  logic                              cpu_we,
  input  logic [ADDR_WIDTH-1:0]             addr,
  input  logic [DATA_WIDTH-1:0]             WriteData,
  input  logic [2:0]                        funct3,
  output logic [DATA_WIDTH-1:0]             cache_read,
  output logic                              stall,
  output logic                              mem_req,
  output logic                              mem_we,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  output logic [BLOCK_WORDS*DATA_WIDTH-1:0] mem_wdata,
  input  logic [BLOCK_WORDS*DATA_WIDTH-1:0] mem_rdata,
  input  logic                              mem_ready
);

  localparam int OFF    = off_w(BLOCK_WORDS);
  localparam int IDX    = idx_w(NUM_SETS);
  localparam int TAG    = tag_w(ADDR_WIDTH, NUM_SETS, BLOCK_WORDS);
  localparam int WSEL   = $clog2(BLOCK_WORDS);
  localparam int LINE_W = BLOCK_WORDS * DATA_WIDTH;

  logic [TAG-1:0]    tag_q  [2][NUM_SETS];
  logic [LINE_W-1:0] line_q [2][NUM_SETS];
  logic [1:0][NUM_SETS-1:0] valid_q;
  logic [1:0][NUM_SETS-1:0] dirty_q;
  logic [NUM_SETS-1:0]      lru_q;
  state_t state_q;
  logic   victim_q;

  logic [IDX-1:0]  idx;
  logic [TAG-1:0]  tag;
  logic [WSEL-1:0] word_sel;
  assign idx      = addr[OFF+IDX-1:OFF];
  assign tag      = addr[ADDR_WIDTH-1:OFF+IDX];
  assign word_sel = addr[OFF-1:2];

  logic hit0, hit1, hit, hit_way, victim;
  assign hit0    = valid_q[0][idx] && (tag_q[0][idx] == tag);
  assign hit1    = valid_q[1][idx] && (tag_q[1][idx] == tag);
  assign hit     = hit0 || hit1;
  assign hit_way = hit1;
  // Fill an empty way before evicting anything.
  assign victim  = !valid_q[0][idx] ? 1'b0 : (!valid_q[1][idx] ? 1'b1 : lru_q[idx]);

  logic lookup, hit_access, miss;
  assign lookup     = (state_q == IDLE) && cpu_req;
  assign hit_access = lookup && hit;
  assign miss       = lookup && !hit;

  // Gated by rst so an abort releases the core in the same cycle.
  assign stall     = !rst && ((state_q != IDLE) || miss);
  assign mem_wdata = line_q[victim_q][idx];

  logic [DATA_WIDTH-1:0] hit_word, store_word;
  logic                  store_en;
  assign hit_word = line_q[hit_way][idx][int'(word_sel)*DATA_WIDTH +: DATA_WIDTH];

  dcache_align u_align (
    .word       (hit_word),
    .wdata      (WriteData),
    .funct3     (funct3),
    .byte_off   (addr[1:0]),
    .load_data  (cache_read),
    .store_word (store_word),
    .store_en   (store_en)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      victim_q <= 1'b0;
      valid_q  <= '0;
      dirty_q  <= '0;
      lru_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hit_access) begin
            lru_q[idx] <= ~hit_way;
            if (cpu_we && store_en) dirty_q[hit_way][idx] <= 1'b1;
          end else if (miss) begin
            victim_q <= victim;
            mem_req  <= 1'b1;
            if (valid_q[victim][idx] && dirty_q[victim][idx]) begin
              state_q  <= WRITEBACK;
              mem_we   <= 1'b1;
              mem_addr <= {tag_q[victim][idx], idx, {OFF{1'b0}}};
            end else begin
              state_q  <= REFILL;
              mem_we   <= 1'b0;
              mem_addr <= {tag, idx, {OFF{1'b0}}};
            end
          end
        end
        WRITEBACK: begin
          if (mem_ready) begin
            state_q  <= REFILL;
            mem_we   <= 1'b0;
            mem_addr <= {tag, idx, {OFF{1'b0}}};
          end
        end
        REFILL: begin
          if (mem_ready) begin
            state_q                <= IDLE;
            mem_req                <= 1'b0;
            valid_q[victim_q][idx] <= 1'b1;
            dirty_q[victim_q][idx] <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: line data and tags are deliberately not reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (hit_access && cpu_we && store_en)
      line_q[hit_way][idx][int'(word_sel)*DATA_WIDTH +: DATA_WIDTH] <= store_word;
    if ((state_q == REFILL) && mem_ready) begin
      line_q[victim_q][idx] <= mem_rdata;
      tag_q[victim_q][idx]  <= tag;
    end
  end

endmodule
